// File: rtl/datapath.sv
// 16-bit register-file datapath: R0..R7, ALU operand A, result G,
// one shared priority-muxed bus, all sequencing driven by external enables.
module datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ext_data,
    input  logic             ext_data_en,
    input  logic [NREGS-1:0] reg_in_en,
    input  logic [NREGS-1:0] reg_out_en,
    input  logic             alu_reg_en,
    input  logic             alu_sel,
    input  logic             g_reg_en,
    input  logic             alu_out_en,
    output logic [WIDTH-1:0] bus,
    output logic             bus_conflict
);

    localparam int CW = $clog2(NREGS + 3);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] g_d;

    logic [WIDTH-1:0] reg_bus;
    logic             reg_hit;
    logic [CW-1:0]    src_cnt;
    logic [WIDTH-1:0] alu_res;

    // Lowest-index enabled register wins among register sources.
    always_comb begin
        reg_bus = '0;
        reg_hit = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_out_en[i] && !reg_hit) begin
                reg_bus = regs_q[i];
                reg_hit = 1'b1;
            end
        end
    end

    always_comb begin
        bus = '0;
        if (ext_data_en) begin
            bus = ext_data;
        end else if (alu_out_en) begin
            bus = g_q;
        end else if (reg_hit) begin
            bus = reg_bus;
        end
    end

    always_comb begin
        src_cnt = CW'(ext_data_en) + CW'(alu_out_en);
        for (int i = 0; i < NREGS; i++) begin
            src_cnt = src_cnt + CW'(reg_out_en[i]);
        end
        bus_conflict = (src_cnt > CW'(1));
    end

    always_comb begin
        alu_res = alu_sel ? (a_q - bus) : (a_q + bus);
    end

    // Reset is folded into the next-state logic so it overrides every load.
    always_comb begin
        a_d = a_q;
        g_d = g_q;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reset) begin
            a_d = '0;
            g_d = '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
        end else begin
            if (alu_reg_en) begin
                a_d = bus;
            end
            if (g_reg_en) begin
                g_d = alu_res;
            end
            for (int i = 0; i < NREGS; i++) begin
                if (reg_in_en[i]) begin
                    regs_d[i] = bus;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q    <= a_d;
        g_q    <= g_d;
        regs_q <= regs_d;
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus random
// enable traffic compared against a behavioural register-file model.
module tb_datapath;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] ext_data;
    logic             ext_data_en;
    logic [NREGS-1:0] reg_in_en;
    logic [NREGS-1:0] reg_out_en;
    logic             alu_reg_en;
    logic             alu_sel;
    logic             g_reg_en;
    logic             alu_out_en;
    logic [WIDTH-1:0] bus;
    logic             bus_conflict;

    int n_checks;
    int n_fails;

    int unsigned m_r [NREGS];
    int unsigned m_a;
    int unsigned m_g;

    datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_data     (ext_data),
        .ext_data_en  (ext_data_en),
        .reg_in_en    (reg_in_en),
        .reg_out_en   (reg_out_en),
        .alu_reg_en   (alu_reg_en),
        .alu_sel      (alu_sel),
        .g_reg_en     (g_reg_en),
        .alu_out_en   (alu_out_en),
        .bus          (bus),
        .bus_conflict (bus_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned model_bus();
        if (ext_data_en) return int'(ext_data);
        if (alu_out_en) return m_g;
        for (int i = 0; i < NREGS; i++)
            if (reg_out_en[i]) return m_r[i];
        return 0;
    endfunction

    function automatic int unsigned model_conflict();
        int n;
        n = int'(ext_data_en) + int'(alu_out_en) + $countones(reg_out_en);
        return (n > 1) ? 1 : 0;
    endfunction

    task automatic clear_en();
        reset       = 1'b0;
        ext_data    = '0;
        ext_data_en = 1'b0;
        reg_in_en   = '0;
        reg_out_en  = '0;
        alu_reg_en  = 1'b0;
        alu_sel     = 1'b0;
        g_reg_en    = 1'b0;
        alu_out_en  = 1'b0;
    endtask

    // Check combinational outputs, then advance one edge and update the model.
    task automatic tick();
        int unsigned b;
        int unsigned res;
        #1;
        b = model_bus();
        check("bus", bus, b);
        check("conflict", bus_conflict, model_conflict());
        res = alu_sel ? ((m_a - b) & 32'hFFFF) : ((m_a + b) & 32'hFFFF);
        @(posedge clk);
        if (reset) begin
            m_a = 0;
            m_g = 0;
            for (int i = 0; i < NREGS; i++) m_r[i] = 0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (reg_in_en[i]) m_r[i] = b;
            if (alu_reg_en) m_a = b;
            if (g_reg_en) m_g = res;
        end
        @(negedge clk);
    endtask

    task automatic expect_now(input string tag, input int unsigned exp);
        #1;
        check(tag, bus, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_a = 0;
        m_g = 0;
        for (int i = 0; i < NREGS; i++) m_r[i] = 0;
        clear_en();
        @(negedge clk);

        reset = 1'b1;
        tick();
        clear_en();
        for (int i = 0; i < NREGS; i++) begin
            reg_out_en = NREGS'(1) << i;
            expect_now("rst_reg", 0);
            tick();
        end
        clear_en();
        alu_out_en = 1'b1;
        expect_now("rst_g", 0);
        tick();

        // load / move
        clear_en();
        ext_data = 16'd4; ext_data_en = 1'b1; reg_in_en = 8'h01;
        tick();
        clear_en();
        reg_out_en = 8'h01; reg_in_en = 8'h02;
        expect_now("move_bus", 4);
        tick();
        clear_en();
        reg_out_en = 8'h02;
        expect_now("r1_val", 4);
        tick();

        // add sequence
        clear_en();
        ext_data = 16'd5; ext_data_en = 1'b1; reg_in_en = 8'h01;
        tick();
        clear_en();
        reg_out_en = 8'h01; alu_reg_en = 1'b1;
        tick();
        clear_en();
        reg_out_en = 8'h02; g_reg_en = 1'b1;
        tick();
        clear_en();
        alu_out_en = 1'b1;
        expect_now("add_g", 9);
        tick();
        expect_now("add_hold", 9);
        tick();

        // subtract with wrap, then add with wrap
        clear_en();
        ext_data = 16'd4; ext_data_en = 1'b1; alu_reg_en = 1'b1;
        tick();
        clear_en();
        ext_data = 16'd5; ext_data_en = 1'b1;
        alu_sel = 1'b1; g_reg_en = 1'b1;
        tick();
        clear_en();
        alu_out_en = 1'b1; alu_reg_en = 1'b1;
        expect_now("sub_wrap", 16'hFFFF);
        tick();
        clear_en();
        ext_data = 16'd1; ext_data_en = 1'b1; g_reg_en = 1'b1;
        tick();
        clear_en();
        alu_out_en = 1'b1;
        expect_now("add_wrap", 0);
        tick();

        // priority / conflict
        clear_en();
        ext_data = 16'h1234; ext_data_en = 1'b1; reg_out_en = 8'h03;
        expect_now("prio_ext", 16'h1234);
        check("prio_conf", bus_conflict, 1);
        tick();
        clear_en();
        reg_out_en = 8'h06;
        expect_now("prio_r1", 4);
        check("prio_conf2", bus_conflict, 1);
        tick();

        // idle bus
        clear_en();
        expect_now("idle", 0);
        check("idle_conf", bus_conflict, 0);
        tick();

        // reset mid-operation: R0=5, A=5, G=9
        clear_en();
        ext_data = 16'd5; ext_data_en = 1'b1;
        reg_in_en = 8'h01; alu_reg_en = 1'b1;
        tick();
        clear_en();
        ext_data = 16'd4; ext_data_en = 1'b1; g_reg_en = 1'b1;
        tick();
        clear_en();
        reset = 1'b1; reg_in_en = 8'hFF;
        ext_data = 16'hABCD; ext_data_en = 1'b1;
        expect_now("rst_bus_comb", 16'hABCD);
        tick();
        clear_en();
        alu_out_en = 1'b1;
        expect_now("mid_rst_g", 0);
        tick();
        clear_en();
        reg_out_en = 8'h01; g_reg_en = 1'b1;
        expect_now("mid_rst_r0", 0);
        tick();
        clear_en();
        alu_out_en = 1'b1;
        expect_now("mid_rst_a", 0);
        tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            clear_en();
            reset = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 3))
                0: ext_data = 16'hFFFF;
                1: ext_data = 16'h0001;
                default: ext_data = 16'($urandom);
            endcase
            ext_data_en = ($urandom_range(0, 3) == 0);
            alu_out_en  = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
                0: reg_out_en = '0;
                1: reg_out_en = 8'($urandom);
                default: reg_out_en = NREGS'(1) << $urandom_range(0, NREGS-1);
            endcase
            reg_in_en  = ($urandom_range(0, 1) == 0) ? '0 : 8'($urandom);
            alu_reg_en = ($urandom_range(0, 2) == 0);
            g_reg_en   = ($urandom_range(0, 2) == 0);
            alu_sel    = 1'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 16-bit register-file datapath: eight general registers R0–R7, ALU operand register A, ALU result register G, one shared 16-bit bus.
- Bus source: external data, G, or one register. Bus sinks: registers, A, and the ALU second operand.
- All sequencing comes from an external control unit (or bench) that drives the one-hot enable signals each cycle.

Parameters:
- WIDTH, 16, data width of bus, registers, A, G, ALU.
- NREGS, 8, number of general registers; width of reg_in_en and reg_out_en.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ext_data  in  WIDTH  external immediate data.
- ext_data_en  in  1  drive ext_data onto the bus.
- reg_in_en  in  NREGS  bit i: load Ri from the bus at the clock edge.
- reg_out_en  in  NREGS  bit i: drive Ri onto the bus.
- alu_reg_en  in  1  load A from the bus at the clock edge.
- alu_sel  in  1  0 = add (A + bus), 1 = subtract (A − bus).
- g_reg_en  in  1  load G with the ALU result at the clock edge.
- alu_out_en  in  1  drive G onto the bus.
- bus  out  WIDTH  current shared bus value (combinational).
- bus_conflict  out  1  high when more than one bus source is enabled (combinational).

Behaviour:
- Reset is synchronous: at a rising clk edge with reset=1, R0–R7, A and G become 0. Reset overrides all load enables in that cycle.
- Bus is a combinational priority mux, not tri-state:
  - ext_data_en → ext_data;
  - else alu_out_en → G;
  - else lowest-index set bit i of reg_out_en → Ri;
  - else 0.
- bus_conflict = 1 when the count of (ext_data_en, alu_out_en, set bits of reg_out_en) is greater than 1. It is informational only; the bus value still follows priority.
- ALU (combinational):
  - result = A + bus when alu_sel=0; A − bus when alu_sel=1.
  - Modulo 2^WIDTH; wrap-around with no carry or overflow retained.
- At the rising edge, when reset=0:
  - each Ri with reg_in_en[i]=1 loads bus; multiple bits set load the same value;
  - alu_reg_en=1 → A loads bus;
  - g_reg_en=1 → G loads the ALU result.
- All loads use pre-edge values. A register driving and loading in the same cycle keeps its value. g_reg_en and alu_out_en together → G loads the ALU result computed from the old G on the bus.
- Latency:
  - bus reflects source changes in the same cycle (zero latency);
  - register contents are visible on the bus one cycle after the load edge;
  - ADD/SUB takes 3 cycles: load A, load G, drive G.
- Registers hold their value whenever their enable is low. No X propagation from an idle bus: an undriven bus reads 0.
- Enables sampled while reset=1 have no effect on state; bus/bus_conflict remain combinational during reset.

Test Plan:
- Load/move: ext_data=4 with ext_data_en, reg_in_en=0x01 → R0=4. Then reg_out_en=0x01, reg_in_en=0x02 → R1=4, bus=4.
- Add sequence:
  - load R0=5;
  - reg_out_en=0x01 + alu_reg_en → A=5;
  - reg_out_en=0x02 + g_reg_en, alu_sel=0 → G=9;
  - alu_out_en → bus=9, held for following cycles.
- Subtract/wrap:
  - A=4, bus=5, alu_sel=1, g_reg_en → G=0xFFFF.
  - A=0xFFFF, bus=1, alu_sel=0 → G=0x0000.
- Priority/conflict: ext_data_en=1 with ext_data=0x1234 and reg_out_en=0x03 → bus=0x1234, bus_conflict=1. With reg_out_en=0x06 only → bus=R1, bus_conflict=1.
- Idle bus: all enables 0 → bus=0, bus_conflict=0, no register changes.
- Reset mid-operation:
  - R0=5, A=5, G=9; assert reset with reg_in_en=0xFF, ext_data_en=1 → all registers, A and G = 0 after the edge.
  - Deassert reset; alu_out_en → bus=0.
